// File: rtl/mixcol_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : mixcol_engine_if
// Description : Valid/ready bus between the round datapath and mixcol_engine.
//               Carries in_bypass only when MIXCOL_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mixcol_engine_if #(
    parameter int NB = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [32*NB-1:0]  in_state;
    logic              in_decrypt;
`ifdef MIXCOL_BYPASS_EN
    logic              in_bypass;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [32*NB-1:0]  out_state;

    modport master (
`ifdef MIXCOL_BYPASS_EN
        output in_bypass,
`endif
        output in_valid, in_state, in_decrypt, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
`ifdef MIXCOL_BYPASS_EN
        input  in_bypass,
`endif
        input  in_valid, in_state, in_decrypt, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface
`default_nettype wire

// File: rtl/mixcol_engine.sv
`default_nettype none
// ============================================================================
// Module      : mixcol_engine
// Description : Iterative AES MixColumns/InvMixColumns over an NB-column state,
//               COLS_PER_CYCLE columns per clock. MIXCOL_BYPASS_EN adds in_bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module mixcol_engine #(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    mixcol_engine_if.slave bus,
    output logic           busy
);
    localparam int                 c_cnt_w = $clog2(NB);
    localparam logic [c_cnt_w-1:0] c_step  = c_cnt_w'(COLS_PER_CYCLE);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(NB - COLS_PER_CYCLE);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    if (COLS_PER_CYCLE < 1) begin : g_bad_cpc_zero
        $error("mixcol_engine: COLS_PER_CYCLE=%0d must be positive", COLS_PER_CYCLE);
    end else if (NB % COLS_PER_CYCLE != 0) begin : g_bad_cpc_div
        $error("mixcol_engine: COLS_PER_CYCLE=%0d does not divide NB=%0d", COLS_PER_CYCLE, NB);
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse mix reuses the forward network after a cheap pre-transform.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic dec);
        logic [7:0]  a [4];
        logic [7:0]  u;
        logic [7:0]  v;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        u = xtime(xtime(a[0] ^ a[2]));
        v = xtime(xtime(a[1] ^ a[3]));
        if (dec) begin
            a[0] = a[0] ^ u;
            a[2] = a[2] ^ u;
            a[1] = a[1] ^ v;
            a[3] = a[3] ^ v;
        end
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = xtime(a[i] ^ a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
        return r;
    endfunction

    logic [1:0]         r_fsm;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_dec;
    logic [31:0]        r_col [NB];
    logic               w_accept;
    logic               w_bypass;
    logic [c_cnt_w-1:0] w_idx [COLS_PER_CYCLE];
    logic [31:0]        w_mix [COLS_PER_CYCLE];
    logic [32*NB-1:0]   w_out;

    assign bus.in_ready  = (r_fsm == c_idle) || ((r_fsm == c_done) && bus.out_ready);
    assign bus.out_valid = (r_fsm == c_done);
    assign busy          = (r_fsm != c_idle);
    assign w_accept      = bus.in_valid && bus.in_ready;

`ifdef MIXCOL_BYPASS_EN
    logic r_bypass;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_bypass <= 1'b0;
        else if (w_accept) r_bypass <= bus.in_bypass;
    end
    assign w_bypass = r_bypass;
`else
    assign w_bypass = 1'b0;
`endif

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        assign w_idx[k] = r_cnt + c_cnt_w'(k);
        assign w_mix[k] = w_bypass ? r_col[w_idx[k]] : mix_col(r_col[w_idx[k]], r_dec);
    end

    // The working registers double as the output holding register.
    always_comb begin
        w_out = '0;
        for (int c = 0; c < NB; c++) w_out[32*NB-1-32*c -: 32] = r_col[c];
    end
    assign bus.out_state = w_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= c_idle;
            r_cnt <= '0;
            r_dec <= 1'b0;
            for (int c = 0; c < NB; c++) r_col[c] <= '0;
        end else begin
            case (r_fsm)
                c_calc: begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++) r_col[w_idx[k]] <= w_mix[k];
                    if (r_cnt == c_last) begin
                        r_fsm <= c_done;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_step;
                    end
                end
                c_done: begin
                    if (bus.out_ready) r_fsm <= c_idle;
                end
                default: r_fsm <= c_idle;
            endcase
            if (w_accept) begin
                r_fsm <= c_calc;
                r_cnt <= '0;
                r_dec <= bus.in_decrypt;
                for (int c = 0; c < NB; c++) r_col[c] <= bus.in_state[32*NB-1-32*c -: 32];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mixcol_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixcol_engine
// Description : Runs three mixcol_engine instances (1, 2, 4 columns/cycle) in
//               lockstep against a matrix-form GF(2^8) reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mixcol_engine;
    localparam int NB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_decrypt;
    logic         in_bypass;
    logic         out_ready;
    logic [127:0] in_state;
    int           n_cmp;
    int           n_fail;

    always #5 clk = ~clk;

    mixcol_engine_if #(.NB(NB)) u_if1 ();
    mixcol_engine_if #(.NB(NB)) u_if2 ();
    mixcol_engine_if #(.NB(NB)) u_if4 ();

    assign u_if1.in_valid = in_valid;   assign u_if2.in_valid = in_valid;   assign u_if4.in_valid = in_valid;
    assign u_if1.in_state = in_state;   assign u_if2.in_state = in_state;   assign u_if4.in_state = in_state;
    assign u_if1.in_decrypt = in_decrypt; assign u_if2.in_decrypt = in_decrypt; assign u_if4.in_decrypt = in_decrypt;
    assign u_if1.out_ready = out_ready; assign u_if2.out_ready = out_ready; assign u_if4.out_ready = out_ready;
`ifdef MIXCOL_BYPASS_EN
    assign u_if1.in_bypass = in_bypass; assign u_if2.in_bypass = in_bypass; assign u_if4.in_bypass = in_bypass;
`endif

    wire [2:0]   bz;
    wire [2:0]   ov = {u_if4.out_valid, u_if2.out_valid, u_if1.out_valid};
    wire [2:0]   ir = {u_if4.in_ready, u_if2.in_ready, u_if1.in_ready};
    wire [127:0] os [3];
    assign os[0] = u_if1.out_state;
    assign os[1] = u_if2.out_state;
    assign os[2] = u_if4.out_state;

    mixcol_engine #(.NB(NB), .COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.slave), .busy(bz[0]));
    mixcol_engine #(.NB(NB), .COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2.slave), .busy(bz[1]));
    mixcol_engine #(.NB(NB), .COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4.slave), .busy(bz[2]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product: rows of {02 03 01 01} or {0e 0b 0d 09}.
    function automatic logic [31:0] ref_col(input logic [31:0] col, input logic dec);
        logic [7:0]  a [4];
        logic [7:0]  coef [4];
        logic [7:0]  acc;
        logic [31:0] r;
        if (dec) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-i+4)%4], a[j]);
            r[31-8*i -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] st, input logic dec, input logic byp);
        logic [127:0] r;
        for (int c = 0; c < NB; c++) r[127-32*c -: 32] = ref_col(st[127-32*c -: 32], dec);
        return byp ? st : r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [127:0] st, input logic dec, input logic byp);
        in_valid   = 1'b1;
        in_state   = st;
        in_decrypt = dec;
        in_bypass  = byp;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_state   = {$urandom, $urandom, $urandom, $urandom};
        in_decrypt = ~dec;
    endtask

    // Waits a bounded number of edges, checks latency and data, then hands off.
    task automatic collect(input logic [127:0] exp, input string tag);
        int lat [3];
        for (int d = 0; d < 3; d++) lat[d] = -1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) if (ov[d] && lat[d] < 0) lat[d] = cyc;
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_lat_cpc%0d", tag, 1 << d), 128'(lat[d]), 128'(4 >> d));
            chk($sformatf("%s_state_cpc%0d", tag, 1 << d), os[d], exp);
        end
        chk($sformatf("%s_inready_held", tag), 128'(ir), 128'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("%s_ov_after", tag), 128'(ov), 128'(0));
        chk($sformatf("%s_busy_after", tag), 128'(bz), 128'(0));
    endtask

    task automatic txn(input logic [127:0] st, input logic dec, input logic byp,
                       input logic [127:0] exp, input string tag);
        chk($sformatf("%s_inready", tag), 128'(ir), 128'h7);
        accept(st, dec, byp);
        collect(exp, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] st;
        logic [127:0] ex;
        logic         dec;
        logic         byp;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; in_state = '0; in_decrypt = 1'b0; in_bypass = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rst_ov", 128'(ov), 128'(0));
        chk("rst_ir", 128'(ir), 128'h7);
        chk("rst_busy", 128'(bz), 128'(0));
        for (int d = 0; d < 3; d++) chk($sformatf("rst_state%0d", d), os[d], 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        txn({4{32'hdb135345}}, 1'b0, 1'b0, {4{32'h8e4da1bc}}, "enc_db13");
        txn({4{32'h8e4da1bc}}, 1'b1, 1'b0, {4{32'hdb135345}}, "dec_8e4d");
        txn({4{32'hf20a225c}}, 1'b0, 1'b0, {4{32'h9fdc589d}}, "enc_f20a");
        txn({4{32'h9fdc589d}}, 1'b1, 1'b0, {4{32'hf20a225c}}, "dec_9fdc");
        txn({32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'hdb135345}, 1'b0, 1'b0,
            {32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h8e4da1bc}, "enc_mixcols");
        txn({32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc, 32'hd5d5d7d6}, 1'b1, 1'b0,
            {32'h01010101, 32'hc6c6c6c6, 32'hdb135345, 32'hd4d4d4d5}, "dec_mixcols");

        // Output stall: results must hold and new offers must be ignored.
        st = {$urandom, $urandom, $urandom, $urandom};
        ex = ref_state(st, 1'b0, 1'b0);
        accept(st, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk($sformatf("hold%0d_ov", i), 128'(ov), 128'h7);
            chk($sformatf("hold%0d_ir", i), 128'(ir), 128'(0));
            for (int d = 0; d < 3; d++) chk($sformatf("hold%0d_state%0d", i, d), os[d], ex);
        end
        st = {$urandom, $urandom, $urandom, $urandom};
        ex = ref_state(st, 1'b1, 1'b0);
        in_state = st; in_decrypt = 1'b1; out_ready = 1'b1;
        #1;
        chk("release_ir", 128'(ir), 128'h7);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("release_busy", 128'(bz), 128'h7);
        collect(ex, "b2b");

        // Reset two cycles into CALC discards everything at once.
        accept({4{32'hdb135345}}, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ov", 128'(ov), 128'(0));
        chk("midrst_ir", 128'(ir), 128'h7);
        chk("midrst_busy", 128'(bz), 128'(0));
        for (int d = 0; d < 3; d++) chk($sformatf("midrst_state%0d", d), os[d], 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        txn({4{32'hf20a225c}}, 1'b0, 1'b0, {4{32'h9fdc589d}}, "post_rst");

        for (int i = 0; i < 20; i++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
`ifdef MIXCOL_BYPASS_EN
            byp = 1'($urandom_range(0, 1));
`else
            byp = 1'b0;
`endif
            txn(st, dec, byp, ref_state(st, dec, byp), $sformatf("rand%0d", i));
        end

`ifdef MIXCOL_BYPASS_EN
        st = {$urandom, $urandom, $urandom, $urandom};
        txn(st, 1'b0, 1'b1, st, "bypass_enc");
        txn(st, 1'b1, 1'b1, st, "bypass_dec");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
